// File: rtl/ysyx_22050039_reg_if.sv
// Signal bundle for one enabled register: the writer drives data and enable,
// the register presents its current value back.
interface ysyx_22050039_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             wen;

    modport master (output din, output wen, input  dout);
    modport slave  (input  din, input  wen, output dout);
endinterface

// File: rtl/ysyx_22050039_reg.sv
// Generic WIDTH-bit register with synchronous active-high reset and write
// enable. Usable as a program counter (wen tied high) or a plain enabled reg.
module ysyx_22050039_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    logic [WIDTH-1:0] r_q;

    // State update: reset has priority over write, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (wen) begin
            r_q <= din;
        end
    end

    assign dout = r_q;

`ifndef SYNTHESIS
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("ysyx_22050039_reg: WIDTH=%0d outside 1..1024", WIDTH);
    end

    // Flag unknown control and data on edges where they would be used.
    always_ff @(posedge clk) begin
        if (!rst && $isunknown(wen)) begin
            $error("ysyx_22050039_reg: wen is X/Z while out of reset");
        end else if (!rst && wen === 1'b1 && $isunknown(din)) begin
            $warning("ysyx_22050039_reg: din has X/Z bits during write");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050039_reg.sv
module tb_ysyx_22050039_reg;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ysyx_22050039_reg_if #(.WIDTH(64)) bus_w ();
    ysyx_22050039_reg_if #(.WIDTH(1))  bus_n ();

    ysyx_22050039_reg #(
        .WIDTH     (64),
        .RESET_VAL (64'(32'h8000_0000))
    ) u_wide (
        .clk  (clk),
        .rst  (rst),
        .din  (bus_w.din),
        .dout (bus_w.dout),
        .wen  (bus_w.wen)
    );

    ysyx_22050039_reg u_narrow (
        .clk  (clk),
        .rst  (rst),
        .din  (bus_n.din),
        .dout (bus_n.dout),
        .wen  (bus_n.wen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: one expected value per clock edge.
    logic [63:0] q_wide[$];
    logic        q_narrow[$];

    // Reference model: the value each register should hold right now.
    logic [63:0] m_wide;
    logic        m_narrow;
    bit          m_valid = 1'b0;

    // Monitor: one edge after each issued step, compare against the queue.
    initial begin
        logic [63:0] ew;
        logic        en;
        forever begin
            @(posedge clk);
            #1;
            if (q_wide.size() != 0) begin
                ew = q_wide.pop_front();
                checks++;
                if (bus_w.dout !== ew) begin
                    errors++;
                    $display("FAIL wide_after_edge got=%h exp=%h t=%0t", bus_w.dout, ew, $time);
                end
            end
            if (q_narrow.size() != 0) begin
                en = q_narrow.pop_front();
                checks++;
                if (bus_n.dout !== en) begin
                    errors++;
                    $display("FAIL narrow_after_edge got=%b exp=%b t=%0t", bus_n.dout, en, $time);
                end
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, confirm outputs have not
    // moved before the rising edge, and queue the post-edge expectation.
    task automatic step(input logic r, input logic w, input logic [63:0] dw, input logic dn);
        @(negedge clk);
        rst       = r;
        bus_w.wen = w;
        bus_n.wen = w;
        bus_w.din = dw;
        bus_n.din = dn;
        #2;
        if (m_valid) begin
            checks++;
            if (bus_w.dout !== m_wide) begin
                errors++;
                $display("FAIL wide_before_edge got=%h exp=%h t=%0t", bus_w.dout, m_wide, $time);
            end
            checks++;
            if (bus_n.dout !== m_narrow) begin
                errors++;
                $display("FAIL narrow_before_edge got=%b exp=%b t=%0t", bus_n.dout, m_narrow, $time);
            end
        end
        if (r) begin
            m_wide   = PC_RESET;
            m_narrow = 1'b0;
            m_valid  = 1'b1;
        end else if (w) begin
            m_wide   = dw;
            m_narrow = dn;
        end
        if (m_valid) begin
            q_wide.push_back(m_wide);
            q_narrow.push_back(m_narrow);
        end
    endtask

    initial begin
        bus_w.din = '0;
        bus_w.wen = 1'b0;
        bus_n.din = '0;
        bus_n.wen = 1'b0;

        // Reset with write asserted and junk data.
        step(1'b1, 1'b1, 64'hDEAD, 1'b1);
        // Write; the before-edge check covers "unchanged before it".
        step(1'b0, 1'b1, 64'h8000_0004, 1'b1);
        // Hold across three edges with toggling data.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, (i % 2 == 0) ? 64'h1234 : 64'h0, 1'b0);
        // Reset wins over write with all-ones data.
        step(1'b1, 1'b1, '1, 1'b1);
        // Load a non-reset value, then raise reset mid-cycle without write.
        step(1'b0, 1'b1, 64'hCAFE_F00D_1234_5678, 1'b1);
        step(1'b1, 1'b0, 64'h5555, 1'b0);
        // Narrow register: reset -> 0, write 1, hold at 1.
        step(1'b0, 1'b1, 64'h1, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 1)));
        end

        // Let the monitor drain the last expectation, bounded.
        for (int i = 0; i < 4 && (q_wide.size() != 0 || q_narrow.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (q_wide.size() != 0 || q_narrow.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q_wide.size(), q_narrow.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
